// File: rtl/bpu_pkg.sv
// Shared BPU types: branch type, BTB entry layout, FSM states and the folded-tag helper.
`default_nettype none

package bpu_pkg;

    localparam int TAG_MAX = 29;

    typedef enum logic [1:0] {
        BR_PC_RELATIVE = 2'd0,
        BR_CALL        = 2'd1,
        BR_RETURN      = 2'd2,
        BR_INDIRECT    = 2'd3
    } br_type_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } btb_state_t;

    // Tag is stored zero-extended to TAG_MAX bits so one struct serves every TAG_WIDTH.
    typedef struct packed {
        logic               valid;
        logic               fsc;
        logic [TAG_MAX-1:0] tag;
        logic [29:0]        bta;
        br_type_t           br_type;
    } btb_entry_t;

    // pc is pc[31:2]: pc[31:32-TW] maps to pc[29:30-TW], pc[TW+2:3] maps to pc[TW:1].
    function automatic logic [TAG_MAX-1:0] mktag(input logic [29:0] pc, input int tag_width);
        logic [TAG_MAX-1:0] t;
        t = '0;
        for (int i = 0; i < TAG_MAX; i++) begin
            if (i < tag_width) begin
                t[i] = pc[30 - tag_width + i] ^ pc[1 + i];
            end
        end
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btb_way.sv
// One BTB way: simple dual-port RAM (registered read) plus tag compare on the read entry.
// With BTB_BYPASS_EN a same-cycle write to the read set is forwarded into the read register.
`default_nettype none

module btb_way
    import bpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  btb_entry_t            wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [TAG_MAX-1:0]    rtag,
    output btb_entry_t            rdata,
    output logic                  hit
);

    btb_entry_t mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef BTB_BYPASS_EN
    always_ff @(posedge clk) begin
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end
`else
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end
`endif

    assign hit = rdata.valid && (rdata.tag == rtag);

endmodule

`default_nettype wire

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with round-robin allocation and sweep invalidate.
// Optional: BTB_BYPASS_EN forwards a same-cycle update to the next-cycle lookup result.
`default_nettype none

module btb_assoc
    import bpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int WAYS       = 2,
    parameter int TAG_WIDTH  = 15,
    localparam int WB        = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    output logic          ready_o,
    input  logic [29:0]   rpc_i,
    input  logic          update_i,
    input  logic [29:0]   wpc_i,
    input  logic [29:0]   bta_i,
    input  br_type_t      br_type_i,
    input  logic          upd_hit_i,
    input  logic [WB-1:0] upd_way_i,
    output logic          miss_o,
    output logic          fsc_o,
    output logic [29:0]   bta_o,
    output br_type_t      br_type_o,
    output logic [WB-1:0] hit_way_o
);

    localparam int NSETS = 2**ADDR_WIDTH;

    btb_state_t            state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic [29:0]           pre_pc;
    logic                  live;
    logic [WB-1:0]         rr_ptr [NSETS];

    logic [ADDR_WIDTH-1:0] idx_r;
    logic [ADDR_WIDTH-1:0] idx_w;
    logic                  sweeping;
    logic                  upd_en;
    logic [WB-1:0]         rr_w;
    logic [WB-1:0]         rr_next;
    logic [WB-1:0]         wr_way;
    logic [ADDR_WIDTH-1:0] waddr;
    btb_entry_t            wdata;
    logic [TAG_MAX-1:0]    pre_tag;
    btb_entry_t            way_rd  [WAYS];
    logic [WAYS-1:0]       way_hit;

    assign idx_r    = rpc_i[ADDR_WIDTH:1];
    assign idx_w    = wpc_i[ADDR_WIDTH:1];
    assign sweeping = (state == ST_INIT);
    assign upd_en   = rst_n && !flush_i && !sweeping && update_i;
    assign rr_w     = rr_ptr[idx_w];
    assign rr_next  = (WAYS == 1) ? '0 : rr_w + WB'(1);
    assign wr_way   = upd_hit_i ? upd_way_i : rr_w;
    assign waddr    = sweeping ? sweep_cnt : idx_w;
    assign pre_tag  = mktag(pre_pc, TAG_WIDTH);

    always_comb begin
        wdata         = '0;
        wdata.br_type = BR_PC_RELATIVE;
        if (!sweeping) begin
            wdata.valid   = 1'b1;
            wdata.fsc     = wpc_i[0];
            wdata.tag     = mktag(wpc_i, TAG_WIDTH);
            wdata.bta     = bta_i;
            wdata.br_type = br_type_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
            ready_o   <= 1'b0;
        end else if (state == ST_INIT) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == '1) begin
                state   <= ST_IDLE;
                ready_o <= 1'b1;
            end
        end
    end

    // live marks a read captured while IDLE; the first result after a sweep may see stale RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_pc <= '0;
            live   <= 1'b0;
        end else begin
            pre_pc <= rpc_i;
            live   <= (state == ST_IDLE) && !flush_i;
        end
    end

    always_ff @(posedge clk) begin
        if (sweeping) begin
            rr_ptr[sweep_cnt] <= '0;
        end else if (upd_en && !upd_hit_i) begin
            rr_ptr[idx_w] <= rr_next;
        end
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        btb_way #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_way (
            .clk   (clk),
            .we    (sweeping || (upd_en && (wr_way == WB'(g)))),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (idx_r),
            .rtag  (pre_tag),
            .rdata (way_rd[g]),
            .hit   (way_hit[g])
        );
    end

    // Scan downward so the lowest-numbered hitting way is the one that sticks.
    always_comb begin
        miss_o    = 1'b1;
        fsc_o     = 1'b0;
        bta_o     = {pre_pc[29:1] + 29'd1, 1'b0};
        br_type_o = BR_PC_RELATIVE;
        hit_way_o = '0;
        if (!sweeping && live) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (way_hit[w]) begin
                    miss_o    = 1'b0;
                    fsc_o     = way_rd[w].fsc;
                    bta_o     = way_rd[w].bta;
                    br_type_o = way_rd[w].br_type;
                    hit_way_o = WB'(w);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_btb_assoc.sv
// Directed and random checks of btb_assoc against a set/way table model kept in the bench.
`default_nettype none

module tb_btb_assoc;
    import bpu_pkg::*;

    localparam int AW   = 8;
    localparam int WAYS = 2;
    localparam int TW   = 15;
    localparam int NS   = 2**AW;
    localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          ready_o;
    logic [29:0]   rpc_i;
    logic          update_i;
    logic [29:0]   wpc_i;
    logic [29:0]   bta_i;
    br_type_t      br_type_i;
    logic          upd_hit_i;
    logic [WB-1:0] upd_way_i;
    logic          miss_o;
    logic          fsc_o;
    logic [29:0]   bta_o;
    br_type_t      br_type_o;
    logic [WB-1:0] hit_way_o;

    btb_assoc #(
        .ADDR_WIDTH (AW),
        .WAYS       (WAYS),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .ready_o   (ready_o),
        .rpc_i     (rpc_i),
        .update_i  (update_i),
        .wpc_i     (wpc_i),
        .bta_i     (bta_i),
        .br_type_i (br_type_i),
        .upd_hit_i (upd_hit_i),
        .upd_way_i (upd_way_i),
        .miss_o    (miss_o),
        .fsc_o     (fsc_o),
        .bta_o     (bta_o),
        .br_type_o (br_type_o),
        .hit_way_o (hit_way_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: per set, WAYS slots plus a round-robin counter.
    bit          m_v   [NS][WAYS];
    int unsigned m_tag [NS][WAYS];
    bit [29:0]   m_bta [NS][WAYS];
    bit [1:0]    m_ty  [NS][WAYS];
    bit          m_fsc [NS][WAYS];
    int          m_rr  [NS];
    int          sweep_left;

    function automatic int f_idx(input bit [29:0] pcv);
        bit [31:0] a;
        a = {pcv, 2'b00};
        return int'((a >> 3) & 32'(NS - 1));
    endfunction

    function automatic int unsigned f_tag(input bit [29:0] pcv);
        bit [31:0] a;
        a = {pcv, 2'b00};
        return (a >> (32 - TW)) ^ ((a >> 3) & ((32'd1 << TW) - 32'd1));
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
        end
        sweep_left = NS;
    endfunction

    function automatic void m_write(input bit [29:0] wpc, input bit [29:0] bta, input bit [1:0] ty,
                                    input bit uh, input int uw);
        int s, w;
        s = f_idx(wpc);
        w = uh ? uw : m_rr[s];
        if (!uh) m_rr[s] = (m_rr[s] + 1) % WAYS;
        m_v[s][w]   = 1'b1;
        m_tag[s][w] = f_tag(wpc);
        m_bta[s][w] = bta;
        m_ty[s][w]  = ty;
        m_fsc[s][w] = wpc[0];
    endfunction

    bit        e_miss;
    bit [29:0] e_bta;
    bit [1:0]  e_ty;
    bit        e_fsc;
    int        e_way;

    function automatic void m_lookup(input bit [29:0] pc, input bit forced);
        int s;
        s      = f_idx(pc);
        e_miss = 1'b1;
        e_bta  = {pc[29:1] + 29'd1, 1'b0};
        e_ty   = 2'd0;
        e_fsc  = 1'b0;
        e_way  = 0;
        if (!forced) begin
            for (int w = 0; w < WAYS; w++) begin
                if (e_miss && m_v[s][w] && m_tag[s][w] == f_tag(pc)) begin
                    e_miss = 1'b0;
                    e_bta  = m_bta[s][w];
                    e_ty   = m_ty[s][w];
                    e_fsc  = m_fsc[s][w];
                    e_way  = w;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model across the edge, compare all outputs.
    task automatic cyc(input bit upd, input bit [29:0] wpc, input bit [29:0] bta, input bit [1:0] ty,
                       input bit uh, input int uw, input bit [29:0] rpc, input bit fl);
        bit ready_pre, forced, byp, do_wr;
        update_i  = upd;
        wpc_i     = wpc;
        bta_i     = bta;
        br_type_i = br_type_t'(ty);
        upd_hit_i = uh;
        upd_way_i = WB'(uw);
        rpc_i     = rpc;
        flush_i   = fl;
        ready_pre = (sweep_left == 0);
        forced    = fl || !ready_pre || !rst_n;
        do_wr     = rst_n && !fl && ready_pre && upd;
`ifdef BTB_BYPASS_EN
        byp = do_wr && (f_idx(wpc) == f_idx(rpc));
`else
        byp = 1'b0;
`endif
        if (byp) m_write(wpc, bta, ty, uh, uw);
        m_lookup(rst_n ? rpc : 30'h0, forced);
        if (!rst_n || fl) m_clear();
        else if (sweep_left > 0) sweep_left--;
        else if (upd && !byp) m_write(wpc, bta, ty, uh, uw);
        @(posedge clk);
        #1;
        check("ready",   32'(ready_o),   32'(sweep_left == 0));
        check("miss",    32'(miss_o),    32'(e_miss));
        check("bta",     32'(bta_o),     32'(e_bta));
        check("br_type", 32'(br_type_o), 32'(e_ty));
        check("fsc",     32'(fsc_o),     32'(e_fsc));
        check("hit_way", 32'(hit_way_o), 32'(e_way));
    endtask

    task automatic idle(input bit [29:0] rpc);
        cyc(1'b0, 30'h0, 30'h0, 2'd0, 1'b0, 0, rpc, 1'b0);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready_o && n < 400) begin
            idle(30'h0);
            n++;
        end
        check(tag, 32'(n), 32'd256);
    endtask

    localparam bit [29:0] PA = 30'h2002;
    localparam bit [29:0] PB = 30'h2202;
    localparam bit [29:0] PC = 30'h2402;
    localparam bit [29:0] PD = 30'h2602;
    localparam bit [29:0] PE = 30'h3006;

    initial begin
        rst_n = 1'b0;
        m_clear();
        for (int i = 0; i < 3; i++) idle(30'h0);
        check("reset_miss", 32'(miss_o), 32'd1);
        check("reset_bta",  32'(bta_o),  32'h2);

        rst_n = 1'b1;
        wait_ready("reset_sweep_len");
        idle(30'h100);
        check("t1_miss", 32'(miss_o), 32'd1);
        check("t1_bta",  32'(bta_o),  32'h102);

        cyc(1'b1, 30'h1000, 30'h2000, 2'd2, 1'b0, 0, 30'h0, 1'b0);
        idle(30'h1000);
        check("t2_miss", 32'(miss_o),    32'd0);
        check("t2_bta",  32'(bta_o),     32'h2000);
        check("t2_type", 32'(br_type_o), 32'd2);
        check("t2_way",  32'(hit_way_o), 32'd0);

        cyc(1'b1, PA, 30'h0AAA, 2'd1, 1'b0, 0, 30'h0, 1'b0);
        cyc(1'b1, PB, 30'h0BBB, 2'd2, 1'b0, 0, 30'h0, 1'b0);
        cyc(1'b1, PC, 30'h0CCC, 2'd3, 1'b0, 0, 30'h0, 1'b0);
        idle(PA);
        check("t3_evicted", 32'(miss_o), 32'd1);
        idle(PB);
        check("t3_b_way", 32'(hit_way_o), 32'd1);
        idle(PC);
        check("t3_c_way", 32'(hit_way_o), 32'd0);

        cyc(1'b1, PB, 30'h0B0B, 2'd2, 1'b1, 1, 30'h0, 1'b0);
        idle(PB);
        check("t4_bta", 32'(bta_o),     32'h0B0B);
        check("t4_way", 32'(hit_way_o), 32'd1);
        cyc(1'b1, PD, 30'h0DDD, 2'd0, 1'b0, 0, 30'h0, 1'b0);
        idle(PD);
        check("t4_rr_way", 32'(hit_way_o), 32'd1);
        idle(PC);
        check("t4_c_kept", 32'(miss_o), 32'd0);

        cyc(1'b1, PE, 30'h0EEE, 2'd3, 1'b0, 0, PE, 1'b0);
`ifdef BTB_BYPASS_EN
        check("t5_bypass_miss", 32'(miss_o), 32'd0);
`else
        check("t5_bypass_miss", 32'(miss_o), 32'd1);
`endif
        idle(PE);
        check("t5_after", 32'(miss_o), 32'd0);

        cyc(1'b0, 30'h0, 30'h0, 2'd0, 1'b0, 0, 30'h0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) cyc(1'b1, 30'h1000, 30'h2000, 2'd2, 1'b0, 0, 30'h1000, 1'b0);
            else idle(30'h1000);
        end
        cyc(1'b0, 30'h0, 30'h0, 2'd0, 1'b0, 0, 30'h0, 1'b1);
        wait_ready("t6_sweep_len");
        idle(30'h1000);
        check("t6_flushed", 32'(miss_o), 32'd1);
        idle(PC);
        check("t6_flushed_c", 32'(miss_o), 32'd1);

        for (int i = 0; i < 700; i++) begin
            bit [29:0] wpc, rpc;
            wpc = 30'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 9) |
                      ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
            rpc = 30'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 9) |
                      ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
            cyc(1'($urandom_range(0, 1)), wpc, 30'($urandom), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0), int'($urandom_range(0, WAYS - 1)), rpc, (i == 150));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
